// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard and stall controller.
// Decides, each cycle, which pipeline registers advance, hold or take a bubble
// for load-use hazards (int and float), taken branches, multi-cycle FP ops
// held in EXE, and data-memory wait. Control outputs are combinational from
// the current inputs and the FP sequencer state, and are forced low in reset.
module hazard_ctrl_unit #(
    parameter int FP_LAT = 4,   // total EXE occupancy of a multi-cycle FP op (2..16)
    parameter int CNT_W  = 32   // width of the stall_cycles counter
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs1_addr,
    input  logic [4:0]       ID_rs2_addr,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [4:0]       ID_frs1_addr,
    input  logic [4:0]       ID_frs2_addr,
    input  logic             ID_use_frs1,
    input  logic             ID_use_frs2,
    input  logic             EXE_MemRead,
    input  logic [4:0]       EXE_rd_addr,
    input  logic             EXE_RegWrite,
    input  logic             EXE_f_RegWrite,
    input  logic             EXE_branch_taken,
    input  logic             EXE_fp_start,
    input  logic             dmem_wait,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idexe_we,
    output logic             idexe_flush,
    output logic             exemem_we,
    output logic             exemem_flush,
    output logic             memwb_we,
    output logic             fp_busy,
    output logic             fp_done,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] FP_INIT = 4'(FP_LAT - 2);

    state_t     state;
    logic [3:0] fp_cnt;
    logic       int_lu;
    logic       flt_lu;
    logic       load_use;
    logic       fp_stall;

    // Hazard detection: integer x0 never creates a dependency, float f0 does.
    always_comb begin
        int_lu = EXE_MemRead && EXE_RegWrite && (EXE_rd_addr != 5'd0) &&
                 ((ID_use_rs1 && (ID_rs1_addr == EXE_rd_addr)) ||
                  (ID_use_rs2 && (ID_rs2_addr == EXE_rd_addr)));
        flt_lu = EXE_MemRead && EXE_f_RegWrite &&
                 ((ID_use_frs1 && (ID_frs1_addr == EXE_rd_addr)) ||
                  (ID_use_frs2 && (ID_frs2_addr == EXE_rd_addr)));
        load_use = int_lu || flt_lu;
        fp_stall = ((state == IDLE) && EXE_fp_start && !dmem_wait) ||
                   ((state == BUSY) && (fp_cnt != 4'd0));
        fp_busy  = rst_n && (state == BUSY);
        fp_done  = rst_n && (state == BUSY) && (fp_cnt == 4'd0);
    end

    // FP sequencer: counts down the EXE occupancy; a finished op is held in
    // BUSY (fp_done high) while data memory stalls the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            fp_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (EXE_fp_start && !dmem_wait) begin
                        state  <= BUSY;
                        fp_cnt <= FP_INIT;
                    end
                end
                BUSY: begin
                    if (fp_cnt != 4'd0) begin
                        fp_cnt <= fp_cnt - 4'd1;
                    end else if (!dmem_wait) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    fp_cnt <= '0;
                end
            endcase
        end
    end

    // Pipeline register control, priority: dmem_wait > fp_stall > branch > load-use.
    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idexe_we     = 1'b1;
        idexe_flush  = 1'b0;
        exemem_we    = 1'b1;
        exemem_flush = 1'b0;
        memwb_we     = 1'b1;
        if (!rst_n || dmem_wait) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            idexe_we  = 1'b0;
            exemem_we = 1'b0;
            memwb_we  = 1'b0;
        end else if (fp_stall) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idexe_we     = 1'b0;
            exemem_flush = 1'b1;
        end else if (EXE_branch_taken) begin
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
        end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idexe_flush = 1'b1;
        end
    end

    // Performance counter: cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!pc_we) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: table of single-cycle vectors in
// IDLE plus hand-written FP-op, FP-op-with-dmem-wait and mid-op reset sequences.
module tb_hazard_ctrl_unit;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic [4:0]       ID_rs1_addr, ID_rs2_addr, ID_frs1_addr, ID_frs2_addr, EXE_rd_addr;
    logic             ID_use_rs1, ID_use_rs2, ID_use_frs1, ID_use_frs2;
    logic             EXE_MemRead, EXE_RegWrite, EXE_f_RegWrite;
    logic             EXE_branch_taken, EXE_fp_start, dmem_wait;
    logic             pc_we, ifid_we, ifid_flush, idexe_we, idexe_flush;
    logic             exemem_we, exemem_flush, memwb_we, fp_busy, fp_done;
    logic [CNT_W-1:0] stall_cycles;

    // Output bit order: pc_we ifid_we ifid_flush idexe_we idexe_flush
    //                   exemem_we exemem_flush memwb_we fp_busy fp_done
    localparam logic [9:0] O_DEF  = 10'b1101010100;
    localparam logic [9:0] O_LU   = 10'b0001110100;
    localparam logic [9:0] O_BR   = 10'b1111110100;
    localparam logic [9:0] O_FRZ  = 10'b0000000000;
    localparam logic [9:0] O_FPS0 = 10'b0000011100;
    localparam logic [9:0] O_FPSB = 10'b0000011110;
    localparam logic [9:0] O_DONE = 10'b1101010111;
    localparam logic [9:0] O_DONW = 10'b0000000011;
    localparam logic [9:0] O_RST  = 10'b0000000000;

    typedef struct {
        logic [4:0] rs1, rs2, frs1, frs2, rd;
        logic       u1, u2, uf1, uf2, mr, rw, frw, br, dw;
        logic [9:0] exp;
    } vec_t;

    vec_t vq[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [CNT_W-1:0] exp_stall = '0;

    hazard_ctrl_unit #(.FP_LAT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .ID_frs1_addr(ID_frs1_addr), .ID_frs2_addr(ID_frs2_addr),
        .ID_use_frs1(ID_use_frs1), .ID_use_frs2(ID_use_frs2),
        .EXE_MemRead(EXE_MemRead), .EXE_rd_addr(EXE_rd_addr),
        .EXE_RegWrite(EXE_RegWrite), .EXE_f_RegWrite(EXE_f_RegWrite),
        .EXE_branch_taken(EXE_branch_taken), .EXE_fp_start(EXE_fp_start),
        .dmem_wait(dmem_wait),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idexe_we(idexe_we), .idexe_flush(idexe_flush),
        .exemem_we(exemem_we), .exemem_flush(exemem_flush), .memwb_we(memwb_we),
        .fp_busy(fp_busy), .fp_done(fp_done), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] rs1, rs2, frs1, frs2, rd,
                                input logic u1, u2, uf1, uf2, mr, rw, frw, br, dw,
                                input logic [9:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.frs1 = frs1; v.frs2 = frs2; v.rd = rd;
        v.u1 = u1; v.u2 = u2; v.uf1 = uf1; v.uf2 = uf2;
        v.mr = mr; v.rw = rw; v.frw = frw; v.br = br; v.dw = dw;
        v.exp = exp;
        return v;
    endfunction

    task automatic clear_inputs();
        ID_rs1_addr = '0; ID_rs2_addr = '0; ID_frs1_addr = '0; ID_frs2_addr = '0;
        EXE_rd_addr = '0;
        ID_use_rs1 = 0; ID_use_rs2 = 0; ID_use_frs1 = 0; ID_use_frs2 = 0;
        EXE_MemRead = 0; EXE_RegWrite = 0; EXE_f_RegWrite = 0;
        EXE_branch_taken = 0; EXE_fp_start = 0; dmem_wait = 0;
    endtask

    // Compare outputs and counter #1 after inputs change, then advance the
    // expected counter by this cycle's expected pc_we.
    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] act;
        #1;
        act = {pc_we, ifid_we, ifid_flush, idexe_we, idexe_flush,
               exemem_we, exemem_flush, memwb_we, fp_busy, fp_done};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s outputs: got %b expected %b", name, act, exp);
        end
        checks++;
        if (stall_cycles !== exp_stall) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cycles, exp_stall);
        end
        if (rst_n && !exp[9]) exp_stall = exp_stall + 1;
    endtask

    task automatic apply(input vec_t v);
        ID_rs1_addr = v.rs1; ID_rs2_addr = v.rs2; ID_frs1_addr = v.frs1; ID_frs2_addr = v.frs2;
        EXE_rd_addr = v.rd;
        ID_use_rs1 = v.u1; ID_use_rs2 = v.u2; ID_use_frs1 = v.uf1; ID_use_frs2 = v.uf2;
        EXE_MemRead = v.mr; EXE_RegWrite = v.rw; EXE_f_RegWrite = v.frw;
        EXE_branch_taken = v.br; EXE_fp_start = 1'b0; dmem_wait = v.dw;
    endtask

    initial begin
        //             rs1 rs2 frs1 frs2 rd  u1 u2 f1 f2 mr rw fw br dw  exp
        vq.push_back(mk(0,  0,  0,   0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF)); // idle
        vq.push_back(mk(1,  5,  0,   0,  5,  1, 1, 0, 0, 1, 1, 0, 0, 0, O_LU));  // lw x5, rs2=x5
        vq.push_back(mk(1,  5,  0,   0,  5,  1, 0, 0, 0, 1, 1, 0, 0, 0, O_DEF)); // rs2 not used
        vq.push_back(mk(0,  3,  0,   0,  0,  1, 1, 0, 0, 1, 1, 0, 0, 0, O_DEF)); // load to x0
        vq.push_back(mk(0,  0,  0,   9,  0,  0, 0, 1, 1, 1, 0, 1, 0, 0, O_LU));  // flw f0, frs1=f0
        vq.push_back(mk(5,  0,  0,   0,  5,  1, 0, 0, 0, 0, 1, 0, 0, 0, O_DEF)); // not a load
        vq.push_back(mk(7,  0,  3,   4,  7,  1, 0, 1, 1, 1, 0, 1, 0, 0, O_DEF)); // float load vs int use
        vq.push_back(mk(0,  0,  0,   0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, O_BR));  // branch
        vq.push_back(mk(8,  0,  0,   0,  8,  1, 0, 0, 0, 1, 1, 0, 1, 0, O_BR));  // branch + load-use
        vq.push_back(mk(8,  0,  0,   0,  8,  1, 0, 0, 0, 1, 1, 0, 0, 1, O_FRZ)); // dmem_wait + load-use
        vq.push_back(mk(0,  0,  0,   0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 1, O_FRZ)); // dmem_wait + branch
        vq.push_back(mk(0,  0,  2, 31,  31,  0, 0, 1, 1, 1, 0, 1, 0, 0, O_LU));  // frs2 match f31
        vq.push_back(mk(31, 4,  0,   0, 31,  1, 0, 0, 0, 1, 1, 0, 0, 0, O_LU));  // rs1 match x31
        vq.push_back(mk(31, 4,  0,   0, 31,  1, 0, 0, 0, 1, 1, 0, 0, 0, O_LU));  // inputs held: stall again
        vq.push_back(mk(0,  0,  0,   0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF)); // back to default

        clear_inputs();
        rst_n = 1'b0;
        // Outputs must stay at reset values even with a load-use pattern present.
        @(negedge clk);
        apply(vq[1]);
        check("reset_hold", O_RST);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        check("after_reset", O_DEF);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            apply(vq[i]);
            check($sformatf("vec%0d", i), vq[i].exp);
        end

        // FP op, FP_LAT=4: stall T..T+2, done T+3, idle T+4.
        @(negedge clk); clear_inputs(); EXE_fp_start = 1; check("fp_T0", O_FPS0);
        @(negedge clk); check("fp_T1", O_FPSB);
        @(negedge clk); check("fp_T2", O_FPSB);
        @(negedge clk); check("fp_T3", O_DONE);
        @(negedge clk); EXE_fp_start = 0; check("fp_T4", O_DEF);

        // FP op with dmem_wait from T+3 for two cycles.
        @(negedge clk); EXE_fp_start = 1; check("fpw_T0", O_FPS0);
        @(negedge clk); check("fpw_T1", O_FPSB);
        @(negedge clk); check("fpw_T2", O_FPSB);
        @(negedge clk); dmem_wait = 1; check("fpw_T3", O_DONW);
        @(negedge clk); check("fpw_T4", O_DONW);
        @(negedge clk); dmem_wait = 0; check("fpw_T5", O_DONE);
        @(negedge clk); EXE_fp_start = 0; check("fpw_T6", O_DEF);

        // Reset asserted mid-op while fp_cnt=1.
        @(negedge clk); EXE_fp_start = 1; check("rst_T0", O_FPS0);
        @(negedge clk); check("rst_T1", O_FPSB);
        @(negedge clk); rst_n = 0; exp_stall = '0; check("rst_mid", O_RST);
        @(negedge clk); EXE_fp_start = 0; rst_n = 1; check("rst_release", O_DEF);
        @(negedge clk); check("rst_idle", O_DEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
